capture_arbiter: RTL and testbench

Round-robin arbiter that shares one enable-gated capture register between `N_REQ` requesters. It accepts one word at a time over a valid/ready handshake and latches it with the winner's index. It presents the result downstream with a valid/ready handshake. An optional idle gap can be enforced between consecutive captures. It sits in front of the shared register stage and replaces ad-hoc `en`/`d` muxing by individual clients.

---
 rtl/capture_arbiter_if.sv | 27 ++
 rtl/capture_arbiter.sv | 99 +++++++++
 tb/tb_capture_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/capture_arbiter_if.sv
// Bundle of the requester-side and downstream-side handshake signals of the
// capture arbiter. The slave modport is the arbiter, the master modport is
// the environment driving requests and consuming the captured word.
interface capture_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int OWN_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       q;
  logic [OWN_W-1:0]       q_owner;
  logic                   q_valid;
  logic                   q_ready;
  logic                   busy;

  modport slave (
    input  req_valid, req_data, q_ready,
    output req_ready, q, q_owner, q_valid, busy
  );

  modport master (
    output req_valid, req_data, q_ready,
    input  req_ready, q, q_owner, q_valid, busy
  );
endinterface

// File: rtl/capture_arbiter.sv
// Round-robin arbiter in front of a single shared capture register.
// One word is accepted at a time, latched together with the winner's index,
// and held until downstream takes it; an optional idle gap follows.
module capture_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0,
  parameter int OWN_W      = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  capture_arbiter_if.slave  bus
);
  // gap counter only has to hold GAP_CYCLES-1
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [OWN_W-1:0] last_grant_q;
  logic [WIDTH-1:0] q_q;
  logic [OWN_W-1:0] owner_q;
  logic             q_valid_q;

  logic [OWN_W-1:0] win_idx;
  logic             win_found;
  logic             accept;
  logic             handshake;

  // Round-robin search: first valid requester starting after last_grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found && bus.req_valid[(int'(last_grant_q) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = OWN_W'((int'(last_grant_q) + k) % N_REQ);
      end
    end
  end

  // Acceptance only in IDLE and never while reset is asserted.
  assign accept    = (state_q == IDLE) && !rst && win_found;
  assign handshake = (state_q == HOLD) && bus.q_ready;

  assign bus.req_ready = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;
  assign bus.q         = q_q;
  assign bus.q_owner   = owner_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.busy      = (state_q != IDLE);

  // Next-state logic and gap counter load/decrement.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: if (accept) state_d = HOLD;
      HOLD: begin
        if (bus.q_ready) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State, capture register and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      last_grant_q <= OWN_W'(N_REQ - 1);
      q_q          <= '0;
      owner_q      <= '0;
      q_valid_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      if (accept) begin
        q_q          <= bus.req_data[int'(win_idx)*WIDTH +: WIDTH];
        owner_q      <= win_idx;
        last_grant_q <= win_idx;
        q_valid_q    <= 1'b1;
      end else if (handshake) begin
        q_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_capture_arbiter.sv
// Directed bench for capture_arbiter. Three instances share one stimulus:
// GAP_CYCLES 0 (main checks), 3 and 1 (gap checks).
module tb_capture_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        q_ready;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  capture_arbiter_if #(.N_REQ(4), .WIDTH(8)) if0 ();
  capture_arbiter_if #(.N_REQ(4), .WIDTH(8)) if3 ();
  capture_arbiter_if #(.N_REQ(4), .WIDTH(8)) if1 ();

  assign if0.req_valid = req_valid;
  assign if0.req_data  = req_data;
  assign if0.q_ready   = q_ready;
  assign if3.req_valid = req_valid;
  assign if3.req_data  = req_data;
  assign if3.q_ready   = q_ready;
  assign if1.req_valid = req_valid;
  assign if1.req_data  = req_data;
  assign if1.q_ready   = q_ready;

  capture_arbiter #(.N_REQ(4), .WIDTH(8), .GAP_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  capture_arbiter #(.N_REQ(4), .WIDTH(8), .GAP_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  capture_arbiter #(.N_REQ(4), .WIDTH(8), .GAP_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Advance one cycle; inputs are changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 4'b0000;
    q_ready   = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; q_ready = 1'b1; req_data = 32'h44332211;
    tick();
    tick();
    #1;
    checks++; if (if0.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", if0.req_ready); end
    checks++; if (if0.q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", if0.q); end
    checks++; if (if0.q_owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", if0.q_owner); end
    checks++; if (if0.q_valid !== 1'b0) begin errors++; $display("FAIL reset_qvalid got %b exp 0", if0.q_valid); end
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", if0.busy); end
    rst = 1'b0;
    #1;
    checks++; if (if0.req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", if0.req_ready); end
    tick();
    checks++; if (if0.q !== 8'h11 || if0.q_owner !== 2'd0) begin errors++; $display("FAIL reset_first_capture got %h/%0d exp 11/0", if0.q, if0.q_owner); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_data = 32'h00A50000; q_ready = 1'b1;
    #1;
    checks++; if (if0.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", if0.req_ready); end
    checks++; if (if0.q_valid !== 1'b0) begin errors++; $display("FAIL single_qvalid_t got %b exp 0", if0.q_valid); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (if0.q !== 8'hA5 || if0.q_owner !== 2'd2 || if0.q_valid !== 1'b1) begin
      errors++; $display("FAIL single_capture got %h/%0d/%b exp a5/2/1", if0.q, if0.q_owner, if0.q_valid); end
    checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", if0.busy); end
    tick();
    checks++; if (if0.q_valid !== 1'b0 || if0.q !== 8'hA5) begin
      errors++; $display("FAIL single_after got %b/%h exp 0/a5", if0.q_valid, if0.q); end
    checks++; if (if0.req_ready !== 4'b0000) begin errors++; $display("FAIL single_idle_ready got %b exp 0000", if0.req_ready); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_all [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] exp_alt [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [3:0] one;
    do_reset();
    req_valid = 4'b1111; req_data = 32'hD3C2B1A0; q_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      #1;
      one = 4'b0001 << exp_all[g];
      checks++; if (if0.req_ready !== one) begin errors++; $display("FAIL rr_all_grant%0d got %b exp %b", g, if0.req_ready, one); end
      tick();
      checks++; if (if0.req_ready !== 4'b0000 || if0.q_owner !== exp_all[g] || if0.q_valid !== 1'b1) begin
        errors++; $display("FAIL rr_all_hold%0d got %b/%0d/%b exp 0000/%0d/1", g, if0.req_ready, if0.q_owner, if0.q_valid, exp_all[g]); end
      tick();
    end
    do_reset();
    req_valid = 4'b1010; q_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      one = 4'b0001 << exp_alt[g];
      checks++; if (if0.req_ready !== one) begin errors++; $display("FAIL rr_alt_grant%0d got %b exp %b", g, if0.req_ready, one); end
      tick();
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b1111; req_data = 32'hD3C2B1A0; q_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++; if (if0.q !== 8'hA0 || if0.q_owner !== 2'd0 || if0.req_ready !== 4'b0000 || if0.q_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d got %h/%0d/%b/%b exp a0/0/0000/1", c, if0.q, if0.q_owner, if0.req_ready, if0.q_valid); end
      tick();
    end
    q_ready = 1'b1;
    #1;
    checks++; if (if0.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_release_ready got %b exp 0000", if0.req_ready); end
    tick();
    checks++; if (if0.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant got %b exp 0010", if0.req_ready); end
  endtask

  task automatic test_gap();
    logic [3:0] exp3 [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    logic       bsy3 [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp1 [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    do_reset();
    req_valid = 4'b1111; req_data = 32'hD3C2B1A0; q_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (if3.req_ready !== exp3[c] || if3.busy !== bsy3[c]) begin
        errors++; $display("FAIL gap3_c%0d got %b/%b exp %b/%b", c, if3.req_ready, if3.busy, exp3[c], bsy3[c]); end
      checks++; if (if1.req_ready !== exp1[c]) begin
        errors++; $display("FAIL gap1_c%0d got %b exp %b", c, if1.req_ready, exp1[c]); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b1111; req_data = 32'hD3C2B1A0; q_ready = 1'b1;
    tick();
    tick();
    q_ready = 1'b0;
    tick();
    checks++; if (if0.q_valid !== 1'b1 || if0.q_owner !== 2'd1 || if0.q !== 8'hB1) begin
      errors++; $display("FAIL mid_pre got %b/%0d/%h exp 1/1/b1", if0.q_valid, if0.q_owner, if0.q); end
    rst = 1'b1;
    #1;
    checks++; if (if0.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", if0.req_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (if0.q_valid !== 1'b0 || if0.q !== 8'h00 || if0.busy !== 1'b0) begin
      errors++; $display("FAIL mid_after got %b/%h/%b exp 0/00/0", if0.q_valid, if0.q, if0.busy); end
    checks++; if (if0.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_restart got %b exp 0001", if0.req_ready); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; q_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
